issue_scoreboard: RTL

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/riscv_pkg.sv | 13 +
 rtl/sb_counter.sv | 41 ++++
 rtl/issue_scoreboard.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the issue scoreboard: register-index width and the
// issue-control state encoding.
package riscv_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        DRAIN   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter. Saturates at all-ones and never
// underflows; a simultaneous valid increment and decrement cancel out.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             inc_ok, dec_ok;

    assign zero_o = (count_q == '0);
    assign full_o = &count_q;

    // Next count: drop an increment at saturation and a decrement at zero.
    always_comb begin
        inc_ok  = inc_i && !full_o;
        dec_ok  = dec_i && !zero_o;
        count_d = count_q;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks pending register writes per architectural register,
// stalls decode on RAW hazards, counter saturation, unresolved control flow
// and post-flush drain. Optional stall-cycle statistics are enabled with the
// SB_STALL_STATS_EN macro (adds the STALL_CYCLES output).
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 DE_V,
    input  logic [REG_IDX_W-1:0] DE_RS1,
    input  logic [REG_IDX_W-1:0] DE_RS2,
    input  logic [REG_IDX_W-1:0] DE_RD,
    input  logic                 DE_USES_RS1,
    input  logic                 DE_USES_RS2,
    input  logic                 DE_WRITES_RD,
    input  logic                 DE_IS_CTRL,
    input  logic                 WB_V,
    input  logic                 WB_REG_WEN,
    input  logic [REG_IDX_W-1:0] WB_DR,
    input  logic                 EXE_BR_RESOLVED,
    input  logic                 FLUSH,
    output logic                 ISSUE,
    output logic                 STALL,
    output logic                 V_DE_FE_BR_STALL,
    output logic [NUM_REGS-1:0]  BUSY,
    output logic                 SB_ERR
`ifdef SB_STALL_STATS_EN
    ,
    output logic [31:0]          STALL_CYCLES
`endif
);

    sb_state_e             state_q, state_d;
    logic                  sb_err_q, sb_err_d;
    logic [NUM_REGS-1:1]   inc_vec, dec_vec, zero_vec, full_vec;
    logic                  raw_hit, sat_hit, issue_wr, wb_wr, err_hit, all_zero;

    // Register 0 has no counter, so it can never read as busy.
    assign BUSY     = {~zero_vec, 1'b0};
    assign all_zero = &zero_vec;
    assign SB_ERR   = sb_err_q;

    // Hazard detection and the zero-latency issue/stall decision.
    always_comb begin
        raw_hit = (DE_USES_RS1 && BUSY[DE_RS1] && (DE_RS1 != '0)) ||
                  (DE_USES_RS2 && BUSY[DE_RS2] && (DE_RS2 != '0));
        sat_hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (DE_WRITES_RD && (DE_RD == REG_IDX_W'(i)) && full_vec[i]) begin
                sat_hit = 1'b1;
            end
        end
        STALL            = DE_V && ((state_q != RUN) || raw_hit || sat_hit);
        ISSUE            = DE_V && !STALL;
        V_DE_FE_BR_STALL = (DE_V && DE_IS_CTRL) || (state_q == BR_WAIT);
    end

    // Decode issue-side increments and writeback-side decrements per register.
    // Decrements use the current count, so a same-cycle writeback never bypasses.
    always_comb begin
        issue_wr = ISSUE && DE_WRITES_RD && (DE_RD != '0);
        wb_wr    = WB_V && WB_REG_WEN && (WB_DR != '0);
        err_hit  = wb_wr && !BUSY[WB_DR];
        for (int i = 1; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_wr && (DE_RD == REG_IDX_W'(i));
            dec_vec[i] = wb_wr && (WB_DR == REG_IDX_W'(i));
        end
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i (CLK),
            .rst_ni(RESET_N),
            .inc_i (inc_vec[g]),
            .dec_i (dec_vec[g]),
            .zero_o(zero_vec[g]),
            .full_o(full_vec[g])
        );
    end

    // Issue-control FSM next state; FLUSH overrides every other transition.
    always_comb begin
        state_d  = state_q;
        sb_err_d = sb_err_q || err_hit;
        if (FLUSH) begin
            state_d = DRAIN;
        end else begin
            unique case (state_q)
                RUN:     if (ISSUE && DE_IS_CTRL) state_d = BR_WAIT;
                BR_WAIT: if (EXE_BR_RESOLVED)     state_d = RUN;
                DRAIN:   if (all_zero)            state_d = RUN;
                default:                          state_d = RUN;
            endcase
        end
    end

    // FSM state and sticky error flag.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= RUN;
            sb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sb_err_q <= sb_err_d;
        end
    end

`ifdef SB_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    assign STALL_CYCLES = stall_cycles_q;

    // Free-running count of stalled decode cycles, wraps naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (STALL) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall statistics register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end
`endif

endmodule
